// File: rtl/rand_arb_pkg.sv
// Shared types and LFSR helpers for the random-request arbiter.
package rand_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam int LFSR_BITS = 10;
    localparam int TAP_HI    = 9;
    localparam int TAP_MID   = 5;
    localparam int TAP_LO    = 0;

    // One Fibonacci shift: feedback enters at the MSB, register shifts right.
    function automatic logic [LFSR_BITS-1:0] lfsr_next(input logic [LFSR_BITS-1:0] r);
        return {r[TAP_HI] ^ r[TAP_MID] ^ r[TAP_LO], r[LFSR_BITS-1:1]};
    endfunction

endpackage

// File: rtl/rand_req_arbiter_if.sv
// Request/grant bundle between the ghost controllers and the random arbiter.
// The seed reload signals exist only when SEED_RELOAD_EN is defined.
interface rand_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LFSR_W  = 10,
    parameter int OUT_W   = 4
);
    logic [NUM_REQ-1:0] i_req;
    logic [NUM_REQ-1:0] o_gnt;
    logic [OUT_W-1:0]   o_rnd_out;
    logic               o_busy;
`ifdef SEED_RELOAD_EN
    logic               i_seed_load;
    logic [LFSR_W-1:0]  i_seed_in;

    modport master (output i_req, output i_seed_load, output i_seed_in,
                    input  o_gnt, input  o_rnd_out,   input  o_busy);
    modport slave  (input  i_req, input  i_seed_load, input  i_seed_in,
                    output o_gnt, output o_rnd_out,   output o_busy);
`else
    modport master (output i_req, input  o_gnt, input  o_rnd_out, input  o_busy);
    modport slave  (input  i_req, output o_gnt, output o_rnd_out, output o_busy);
`endif
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [PTR_W-1:0]   o_winner,
    output logic               o_valid
);

    int  w_idx;
    logic w_found;

    // Scan NUM_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_winner = PTR_W'(w_idx);
                w_found  = 1'b1;
            end else begin
                w_found  = w_found;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/rand_req_arbiter.sv
// Round-robin arbiter sharing one 10-bit LFSR among NUM_REQ requesters.
// Optional feature macro: SEED_RELOAD_EN (runtime seed load while IDLE).
module rand_req_arbiter
    import rand_arb_pkg::*;
#(
    parameter int                NUM_REQ = 4,
    parameter int                LFSR_W  = 10,
    parameter int                OUT_W   = 4,
    parameter int                STEPS   = 3,
    parameter logic [LFSR_W-1:0] SEED    = 10'h001
) (
    input  logic               clk,
    input  logic               rst,
    rand_req_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t             r_state,    w_state_nxt;
    logic [LFSR_W-1:0]  r_lfsr,     w_lfsr_nxt;
    logic [PTR_W-1:0]   r_rr_ptr,   w_rr_nxt;
    logic [PTR_W-1:0]   r_winner,   w_winner_nxt;
    logic [3:0]         r_step_cnt, w_step_nxt;
    logic [NUM_REQ-1:0] r_gnt,      w_gnt_nxt;
    logic [OUT_W-1:0]   r_rnd_out,  w_rnd_nxt;
    logic               r_busy;

    logic [LFSR_W-1:0]  w_lfsr_shift;
    logic [PTR_W-1:0]   w_pick;
    logic               w_pick_valid;

    assign w_lfsr_shift = lfsr_next(r_lfsr);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req    (bus.i_req),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_pick),
        .o_valid  (w_pick_valid)
    );

    // Next-state and datapath updates; the grant is decided on the last STEP edge
    // so the registered pulse lines up exactly with the GRANT state.
    always_comb begin
        w_state_nxt  = r_state;
        w_lfsr_nxt   = r_lfsr;
        w_rr_nxt     = r_rr_ptr;
        w_winner_nxt = r_winner;
        w_step_nxt   = r_step_cnt;
        w_gnt_nxt    = '0;
        w_rnd_nxt    = r_rnd_out;
        case (r_state)
            IDLE: begin
`ifdef SEED_RELOAD_EN
                if (bus.i_seed_load) begin
                    w_lfsr_nxt = (bus.i_seed_in == '0) ? SEED : bus.i_seed_in;
                end else if (w_pick_valid) begin
                    w_winner_nxt = w_pick;
                    w_step_nxt   = 4'(STEPS);
                    w_state_nxt  = STEP;
                end else begin
                    w_state_nxt  = IDLE;
                end
`else
                if (w_pick_valid) begin
                    w_winner_nxt = w_pick;
                    w_step_nxt   = 4'(STEPS);
                    w_state_nxt  = STEP;
                end else begin
                    w_state_nxt  = IDLE;
                end
`endif
            end
            STEP: begin
                w_lfsr_nxt = w_lfsr_shift;
                w_step_nxt = r_step_cnt - 4'd1;
                if (r_step_cnt == 4'd1) begin
                    w_state_nxt = GRANT;
                    // A winner that dropped its request is skipped without moving rr_ptr.
                    if (bus.i_req[r_winner]) begin
                        w_gnt_nxt[r_winner] = 1'b1;
                        w_rnd_nxt = w_lfsr_shift[OUT_W-1:0];
                        w_rr_nxt  = (r_winner == PTR_W'(NUM_REQ - 1)) ? '0
                                                                      : r_winner + PTR_W'(1);
                    end else begin
                        w_gnt_nxt = '0;
                    end
                end else begin
                    w_state_nxt = STEP;
                end
            end
            GRANT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, LFSR and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lfsr     <= SEED;
            r_rr_ptr   <= '0;
            r_winner   <= '0;
            r_step_cnt <= 4'd0;
            r_gnt      <= '0;
            r_rnd_out  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_winner   <= w_winner_nxt;
            r_step_cnt <= w_step_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rnd_out  <= w_rnd_nxt;
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    assign bus.o_gnt     = r_gnt;
    assign bus.o_rnd_out = r_rnd_out;
    assign bus.o_busy    = r_busy;

endmodule

// File: tb/tb_rand_req_arbiter.sv
// Scoreboard bench for rand_req_arbiter (NUM_REQ=4, OUT_W=10, STEPS=2, SEED=1).
module tb_rand_req_arbiter;

    localparam int          NR     = 4;
    localparam int          LW     = 10;
    localparam int          OW     = 10;
    localparam int          ST     = 2;
    localparam logic [9:0]  SEED_V = 10'h001;

    typedef struct {
        logic [3:0] gnt;
        logic [9:0] rnd;
        int         edge_no;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [9:0] m_lfsr = SEED_V;
    logic [9:0] m_rnd  = 10'h000;
    int         m_rr   = 0;

    always #5 clk = ~clk;

    rand_req_arbiter_if #(.NUM_REQ(NR), .LFSR_W(LW), .OUT_W(OW)) bus();

    rand_req_arbiter #(
        .NUM_REQ (NR),
        .LFSR_W  (LW),
        .OUT_W   (OW),
        .STEPS   (ST),
        .SEED    (SEED_V)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] m_step(input logic [9:0] x);
        return {x[9] ^ x[5] ^ x[0], x[9:1]};
    endfunction

    function automatic int m_pick(input logic [3:0] r);
        for (int k = 0; k < NR; k++) begin
            if (r[(m_rr + k) % NR]) return (m_rr + k) % NR;
        end
        return 0;
    endfunction

    // Every grant pulse must match the head of the scoreboard, in value and cycle.
    always @(negedge clk) begin
        if (!rst && bus.o_gnt != 4'b0000) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_gnt", 32'(bus.o_gnt), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("gnt",       32'(bus.o_gnt),     32'(mon_e.gnt));
                check_val("rnd_out",   32'(bus.o_rnd_out), 32'(mon_e.rnd));
                check_val("gnt_cycle", 32'(cyc),           32'(mon_e.edge_no));
            end
        end
    end

    // Called at a negedge while the DUT is IDLE; returns at the negedge before the next sample edge.
    task automatic txn(input logic [3:0] pat, input bit drop);
        int   w;
        exp_t e;
        bus.i_req = pat;
        w = m_pick(pat);
        for (int s = 0; s < ST; s++) m_lfsr = m_step(m_lfsr);
        if (!drop) begin
            e.gnt     = 4'(1 << w);
            e.rnd     = m_lfsr;
            e.edge_no = cyc + 1 + ST;
            sb_q.push_back(e);
            m_rnd = m_lfsr;
            m_rr  = (w + 1) % NR;
        end
        @(negedge clk);
        check_val("busy_step", 32'(bus.o_busy), 32'd1);
        if (drop) bus.i_req = 4'b0000;
        repeat (ST + 1) @(negedge clk);
        check_val("busy_idle", 32'(bus.o_busy), 32'd0);
        check_val("rnd_hold",  32'(bus.o_rnd_out), 32'(m_rnd));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_lfsr = SEED_V;
        m_rr   = 0;
        m_rnd  = 10'h000;
        sb_q.delete();
    endtask

    initial begin
        bus.i_req = 4'b0000;
`ifdef SEED_RELOAD_EN
        bus.i_seed_load = 1'b0;
        bus.i_seed_in   = 10'h000;
`endif
        @(negedge clk);
        do_reset();

        // T1: idle after reset
        repeat (20) @(negedge clk);
        check_val("t1_gnt",  32'(bus.o_gnt),     32'd0);
        check_val("t1_busy", 32'(bus.o_busy),    32'd0);
        check_val("t1_rnd",  32'(bus.o_rnd_out), 32'd0);

        // T2: single grant from the seed
        txn(4'b0001, 1'b0);
        check_val("t2_rnd_const", 32'(bus.o_rnd_out), 32'h300);

        // T4: withdrawn request, then normal grant
        txn(4'b0100, 1'b1);
        check_val("t4_rnd_kept", 32'(bus.o_rnd_out), 32'h300);
        txn(4'b0100, 1'b0);

        // T5: reset during STEP
        bus.i_req = 4'b0001;
        @(negedge clk);
        check_val("t5_busy_before", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        bus.i_req = 4'b0000;
        #1;
        check_val("t5_busy_rst", 32'(bus.o_busy),    32'd0);
        check_val("t5_rnd_rst",  32'(bus.o_rnd_out), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_lfsr = SEED_V;
        m_rr   = 0;
        m_rnd  = 10'h000;
        repeat (3) @(negedge clk);
        check_val("t5_no_gnt", 32'(bus.o_gnt), 32'd0);
        txn(4'b0001, 1'b0);
        check_val("t5_rnd_const", 32'(bus.o_rnd_out), 32'h300);

        // T3: all requesting, order 0,1,2,3,0 then wrap cases
        do_reset();
        for (int i = 0; i < 5; i++) txn(4'b1111, 1'b0);
        check_val("t3_rr", 32'(m_rr), 32'd1);
        txn(4'b1001, 1'b0);
        txn(4'b1001, 1'b0);
        bus.i_req = 4'b0000;
        repeat (3) @(negedge clk);

`ifdef SEED_RELOAD_EN
        // T6: zero seed maps to SEED, load beats a simultaneous request
        bus.i_seed_load = 1'b1;
        bus.i_seed_in   = 10'h000;
        bus.i_req       = 4'b0001;
        @(negedge clk);
        bus.i_seed_load = 1'b0;
        bus.i_req       = 4'b0000;
        m_lfsr = SEED_V;
        check_val("t6_load_no_busy", 32'(bus.o_busy), 32'd0);
        txn(4'b0100, 1'b0);
        bus.i_seed_load = 1'b1;
        bus.i_seed_in   = 10'h155;
        @(negedge clk);
        bus.i_seed_load = 1'b0;
        m_lfsr = 10'h155;
        txn(4'b0001, 1'b0);
`endif

        repeat (5) @(negedge clk);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
